// File: rtl/ysyx_23060332_lsu.sv
// ysyx_23060332_lsu: NPC load/store unit turning one EXU access into word-aligned, byte-masked memory beats.
// Define YSYX_23060332_LSU_SPLIT_EN to split word-crossing accesses into two beats; otherwise they fault.
module ysyx_23060332_lsu #(
    parameter logic [31:0] MEM_BASE = 32'h80000000,
    parameter logic [31:0] MEM_TOP  = 32'h87ffffff
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata
);
`ifdef YSYX_23060332_LSU_SPLIT_EN
    localparam int MW = 8;
    localparam int WW = 64;
    localparam logic [2:0] REQ1  = 3'd3;
    localparam logic [2:0] WAIT1 = 3'd4;
`else
    localparam int MW = 4;
    localparam int WW = 32;
`endif
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ0  = 3'd1;
    localparam logic [2:0] WAIT0 = 3'd2;
    localparam logic [2:0] RESP  = 3'd5;

    logic [2:0]    state_q, state_d;
    logic          wen_q, wen_d, uns_q, uns_d, err_q, err_d;
    logic [31:0]   addr_q, addr_d, lo_q, lo_d;
    logic [1:0]    size_q, size_d;
    logic [MW-1:0] m8_q, m8_d, m8_n;
    logic [WW-1:0] w64_q, w64_d, w64_n, rd_all;
    logic [1:0]    lmask;
    logic [3:0]    base4, beat_mask;
    logic [32:0]   last;
    logic          bad, hi_beat;
    logic [31:0]   beat_data, sh, ext;
`ifdef YSYX_23060332_LSU_SPLIT_EN
    logic [31:0]   hi_q, hi_d;
`endif

    always_comb begin
        lmask = req_size == 2'd0 ? 2'd0 : req_size == 2'd1 ? 2'd1 : 2'd3;
        base4 = req_size == 2'd0 ? 4'h1 : req_size == 2'd1 ? 4'h3 : 4'hf;
        last  = {1'b0, req_addr} + {31'b0, lmask};
        bad   = req_size == 2'b11 || req_addr < MEM_BASE || last > {1'b0, MEM_TOP};
`ifndef YSYX_23060332_LSU_SPLIT_EN
        bad   = bad || (req_addr[1:0] & lmask) != 2'b00;
`endif
        m8_n  = MW'(base4) << req_addr[1:0];
        w64_n = WW'(req_wdata) << {req_addr[1:0], 3'b000};
    end

    always_comb begin
        state_d = state_q;
        wen_d   = wen_q;
        uns_d   = uns_q;
        err_d   = err_q;
        addr_d  = addr_q;
        size_d  = size_q;
        m8_d    = m8_q;
        w64_d   = w64_q;
        lo_d    = lo_q;
`ifdef YSYX_23060332_LSU_SPLIT_EN
        hi_d    = hi_q;
`endif
        case (state_q)
            IDLE: if (req_valid) begin
                wen_d   = req_wen;
                uns_d   = req_unsigned;
                err_d   = bad;
                addr_d  = req_addr;
                size_d  = req_size;
                m8_d    = m8_n;
                w64_d   = w64_n;
                state_d = bad ? RESP : REQ0;
            end
            REQ0: if (mem_req_ready) state_d = WAIT0;
            WAIT0: if (mem_rsp_valid) begin
                lo_d = mem_rdata;
`ifdef YSYX_23060332_LSU_SPLIT_EN
                state_d = |m8_q[7:4] ? REQ1 : RESP;
`else
                state_d = RESP;
`endif
            end
`ifdef YSYX_23060332_LSU_SPLIT_EN
            REQ1: if (mem_req_ready) state_d = WAIT1;
            WAIT1: if (mem_rsp_valid) begin
                hi_d    = mem_rdata;
                state_d = RESP;
            end
`endif
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wen_q   <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            m8_q    <= '0;
            w64_q   <= '0;
            lo_q    <= '0;
`ifdef YSYX_23060332_LSU_SPLIT_EN
            hi_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            wen_q   <= wen_d;
            uns_q   <= uns_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            m8_q    <= m8_d;
            w64_q   <= w64_d;
            lo_q    <= lo_d;
`ifdef YSYX_23060332_LSU_SPLIT_EN
            hi_q    <= hi_d;
`endif
        end
    end

`ifdef YSYX_23060332_LSU_SPLIT_EN
    assign hi_beat   = state_q == REQ1;
    assign beat_mask = hi_beat ? m8_q[7:4] : m8_q[3:0];
    assign beat_data = hi_beat ? w64_q[63:32] : w64_q[31:0];
    assign rd_all    = {hi_q, lo_q};
`else
    assign hi_beat   = 1'b0;
    assign beat_mask = m8_q;
    assign beat_data = w64_q;
    assign rd_all    = lo_q;
`endif

    // Outputs decode only from registered state so req_* never reaches mem_* combinationally.
    assign req_ready     = state_q == IDLE;
    assign mem_req_valid = state_q == REQ0 || hi_beat;
    assign mem_wen       = mem_req_valid && wen_q;
    assign mem_addr      = mem_req_valid ? {addr_q[31:2] + 30'(hi_beat), 2'b00} : 32'b0;
    assign mem_wmask     = mem_wen ? beat_mask : 4'b0;
    assign mem_wdata     = mem_req_valid ? beat_data : 32'b0;

    assign sh  = 32'(rd_all >> {addr_q[1:0], 3'b000});
    assign ext = size_q == 2'd0 ? {{24{!uns_q && sh[7]}}, sh[7:0]}
               : size_q == 2'd1 ? {{16{!uns_q && sh[15]}}, sh[15:0]} : sh;

    assign rsp_valid = state_q == RESP;
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && !err_q && !wen_q) ? ext : 32'b0;
endmodule

// File: doc/ysyx_23060332_lsu.md
# ysyx_23060332_lsu

Load/store unit for the NPC core: the initiator side of the data-memory interface. Accepts one load or store from the EXU, converts it into one or two word-aligned, byte-masked memory transactions, then merges, shifts and sign/zero-extends the load data. Returns a single response to the WBU. Sits between EXU/WBU and the data-memory responder.

## Interface
- Parameters:
  - `MEM_BASE`, default 32'h80000000: lowest legal byte address.
  - `MEM_TOP`, default 32'h87ffffff: highest legal byte address.
- Ports:
  - `clk` input 1: clock; all logic is on the rising edge.
  - `rst_n` input 1: reset; asynchronous, active-low.
  - `req_valid` input 1: EXU request valid.
  - `req_ready` output 1: LSU can accept a request; high only in IDLE.
  - `req_wen` input 1: 1 = store, 0 = load.
  - `req_addr` input 32: byte address.
  - `req_wdata` input 32: store data, LSB-justified.
  - `req_size` input 2: 00 byte, 01 half, 10 word, 11 illegal.
  - `req_unsigned` input 1: zero-extend the load (LBU/LHU).
  - `rsp_valid` output 1: response valid.
  - `rsp_ready` input 1: WBU accepts the response.
  - `rsp_rdata` output 32: extended load data; 0 for stores and errors.
  - `rsp_err` output 1: access fault (illegal size, out of range, or misaligned when split is disabled).
  - `mem_req_valid` output 1: memory request valid.
  - `mem_req_ready` input 1: memory accepts the request.
  - `mem_wen` output 1: memory write.
  - `mem_addr` output 32: word-aligned address; bits [1:0] are always 0.
  - `mem_wdata` output 32: lane-aligned write data.
  - `mem_wmask` output 4: byte-lane write mask; 0 on reads.
  - `mem_rsp_valid` input 1: memory response (read data or write acknowledge).
  - `mem_rdata` input 32: read word.

## Operation
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE, on `req_valid && req_ready`:
  - Latch the request. Compute `off = addr[1:0]`.
  - Compute `m8 = ({1,3,15}[size] << off)`, 8-bit wide.
  - Compute `w64 = {32'b0, wdata} << (8*off)`.
- Error check, evaluated in IDLE on accept:
  - `size==11`, `addr < MEM_BASE`, or `addr+bytes-1 > MEM_TOP`.
  - On any of these, go directly to RESP with `rsp_err=1`. No memory transaction is issued.
- Otherwise go to REQ0.
- REQ0:
  - Drive `mem_addr = {addr[31:2],2'b0}`, `mem_wmask = m8[3:0]` (stores only), `mem_wdata = w64[31:0]`.
  - Hold all of these stable until `mem_req_ready`, then go to WAIT0.
- WAIT0:
  - On `mem_rsp_valid`, latch `mem_rdata` into `lo`.
  - If `m8[7:4]!=0`, go to REQ1; otherwise go to RESP.
- REQ1/WAIT1: same as REQ0/WAIT0 with `mem_addr+4`, `m8[7:4]`, `w64[63:32]`. The response is latched into `hi`.
- Load result: `sh = {hi,lo} >> (8*off)`. Take the low 8/16/32 bits and sign-extend unless `req_unsigned`.
- RESP: assert `rsp_valid` and hold it until `rsp_ready`, then return to IDLE.
- `mem_rsp_valid` outside WAIT0/WAIT1 is ignored.
- At most one outstanding memory request.

## Timing
- Reset: state=IDLE and all outputs are 0 except `req_ready=1`.
- Reset mid-transaction aborts immediately. The in-flight memory response is dropped and no response is emitted.
- All outputs are registered or decoded from state only; there is no combinational path from `req_*` to `mem_*`.
- Latency with a zero-wait memory (`mem_req_ready=1`, `mem_rsp_valid` one cycle after the request handshake), from the accept edge:
  - Aligned access: `mem_req_valid` in cycle 1, response in cycle 2, `rsp_valid` in cycle 3.
  - Split access: `rsp_valid` in cycle 5.
  - Error: `rsp_valid` in cycle 1.
- Back-to-back requests: `req_ready` rises in the cycle after the `rsp_valid && rsp_ready` handshake.

## Configuration
- `YSYX_23060332_LSU_SPLIT_EN` defined: accesses that cross a word boundary are split into two beats as described above.
- Macro not defined:
  - Any access with `(addr & (bytes-1)) != 0` is an error: RESP with `rsp_err=1` and no memory traffic.
  - Aligned sub-word accesses still use lane shifting.
  - REQ1/WAIT1 are not compiled in.

## Test plan
- Aligned load: LW @0x80000000 with memory word 0xDEADBEEF → one read with mask 0; `rsp_rdata=0xDEADBEEF`, `rsp_err=0`, `rsp_valid` in cycle 3.
- Sign extension: LB @0x80000003 with word 0x80FFFFFF → `rsp_rdata=0xFFFFFF80`. LBU at the same address → `rsp_rdata=0x00000080`.
- Byte-lane store: SH @0x80000002 with `wdata=0x1234ABCD` → `mem_wmask=4'b1100`, `mem_wdata=0xABCD0000`, single beat.
- Split store (macro defined): SW @0x80000001 with `wdata=0x11223344`:
  - Beat 0: `mem_addr=0x80000000`, `mem_wmask=1110`, `mem_wdata=0x22334400`.
  - Beat 1: `mem_addr=0x80000004`, `mem_wmask=0001`, `mem_wdata=0x00000011`.
  - Macro undefined: `rsp_err=1` and no `mem_req_valid`.
- Range and size errors: LW @0x7FFFFFFC, LW @0x87FFFFFE (macro defined), or `req_size=11` → `rsp_err=1`, `rsp_rdata=0`, zero memory requests.
- Stalls and reset:
  - Hold `mem_req_ready=0` for 4 cycles: `mem_*` outputs stay stable.
  - Hold `rsp_ready=0` for 3 cycles: `rsp_valid` stays high with the data held.
  - Assert `rst_n=0` while in WAIT0: outputs clear asynchronously, the late `mem_rsp_valid` is ignored, and the next request completes normally.
